// File: rtl/ascon_regs_fifo.sv
// ============================================================================
// Module      : ascon_regs_fifo
// Description : Bus register block for the Ascon accelerator with BDI/BDO
//               FIFOs, self-clearing start pulse and sticky status/interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ascon_regs_fifo_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic [CW-1:0]    o_count,
    output logic             o_full,
    output logic             o_empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign w_do_pop  = i_pop & ~o_empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_count   = r_count;
    assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push && !i_clr && !rst) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end
endmodule

module ascon_regs_fifo #(
    parameter int ADDR_WIDTH  = 8,
    parameter int KEY_WORDS   = 4,
    parameter int NONCE_WORDS = 3,
    parameter int BDI_DEPTH   = 4,
    parameter int BDO_DEPTH   = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_i,
    input  logic                      we_i,
    input  logic [ADDR_WIDTH-1:0]     addr_i,
    input  logic [31:0]               wdata_i,
    output logic [31:0]               rdata_o,
    output logic                      rvalid_o,
    output logic [3:0]                mode_o,
    output logic                      start_o,
    input  logic                      done_i,
    input  logic                      auth_i,
    output logic [32*KEY_WORDS-1:0]   key_o,
    output logic [32*NONCE_WORDS-1:0] nonce_o,
    output logic [31:0]               bdi_data_o,
    output logic [3:0]                bdi_type_o,
    output logic                      bdi_valid_o,
    input  logic                      bdi_ready_i,
    input  logic [31:0]               bdo_data_i,
    input  logic                      bdo_valid_i,
    output logic                      bdo_ready_o,
    output logic                      irq_o
);
    localparam int BDI_CW = $clog2(BDI_DEPTH) + 1;
    localparam int BDO_CW = $clog2(BDO_DEPTH) + 1;

    localparam logic [7:0]  c_ADDR_CTRL   = 8'h00;
    localparam logic [7:0]  c_ADDR_STATUS = 8'h04;
    localparam logic [7:0]  c_ADDR_KEY    = 8'h08;
    localparam logic [7:0]  c_ADDR_NONCE  = 8'h20;
    localparam logic [7:0]  c_ADDR_BDI    = 8'h30;
    localparam logic [7:0]  c_ADDR_TYPE   = 8'h34;
    localparam logic [7:0]  c_ADDR_BDO    = 8'h38;
    localparam logic [31:0] c_BAD_READ    = 32'hDEAD_BEEF;

    logic [7:0]  w_addr8;
    logic        w_addr_ok;
    logic        w_rd;
    logic        w_wr;
    logic        w_wr_ctrl;
    logic        w_wr_status;
    logic        w_wr_bdi;
    logic        w_wr_type;
    logic        w_rd_bdo;
    logic        w_start_ok;
    logic        w_fifo_clr;
    logic        w_bdi_ovf;
    logic        w_bdo_udf;
    logic [31:0] w_rdata;
    logic [31:0] w_status;

    logic [3:0]  r_mode;
    logic        r_irq_en;
    logic        r_start;
    logic        r_busy;
    logic        r_done;
    logic        r_ovf;
    logic        r_udf;
    logic        r_irq;
    logic [3:0]  r_bdi_type;
    logic [31:0] r_rdata;
    logic        r_rvalid;
    logic [31:0] r_key   [KEY_WORDS];
    logic [31:0] r_nonce [NONCE_WORDS];

    logic [35:0]       w_bdi_head;
    logic [BDI_CW-1:0] w_bdi_cnt;
    logic              w_bdi_full;
    logic              w_bdi_empty;
    logic [31:0]       w_bdo_head;
    logic [BDO_CW-1:0] w_bdo_cnt;
    logic              w_bdo_full;
    logic              w_bdo_empty;

    assign w_addr8 = addr_i[7:0];

    generate
        if (ADDR_WIDTH > 8) begin : g_addr_hi
            assign w_addr_ok = (addr_i[ADDR_WIDTH-1:8] == '0);
        end else begin : g_addr_8
            assign w_addr_ok = 1'b1;
        end
    endgenerate

    assign w_rd        = req_i & ~we_i;
    assign w_wr        = req_i & we_i;
    assign w_wr_ctrl   = w_wr & w_addr_ok & (w_addr8 == c_ADDR_CTRL);
    assign w_wr_status = w_wr & w_addr_ok & (w_addr8 == c_ADDR_STATUS);
    assign w_wr_bdi    = w_wr & w_addr_ok & (w_addr8 == c_ADDR_BDI);
    assign w_wr_type   = w_wr & w_addr_ok & (w_addr8 == c_ADDR_TYPE);
    assign w_rd_bdo    = w_rd & w_addr_ok & (w_addr8 == c_ADDR_BDO);
    assign w_start_ok  = w_wr_ctrl & wdata_i[0] & ~r_busy;
    assign w_fifo_clr  = w_wr_ctrl & wdata_i[6];
    // Full implies non-empty, so a ready core always frees a slot this cycle
    assign w_bdi_ovf   = w_wr_bdi & w_bdi_full & ~bdi_ready_i;
    assign w_bdo_udf   = w_rd_bdo & w_bdo_empty;

    ascon_regs_fifo_buf #(
        .WIDTH (36),
        .DEPTH (BDI_DEPTH),
        .CW    (BDI_CW)
    ) u_bdi (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_clr   (w_fifo_clr),
        .i_push  (w_wr_bdi),
        .i_pop   (bdi_ready_i),
        .i_data  ({r_bdi_type, wdata_i}),
        .o_data  (w_bdi_head),
        .o_count (w_bdi_cnt),
        .o_full  (w_bdi_full),
        .o_empty (w_bdi_empty)
    );

    ascon_regs_fifo_buf #(
        .WIDTH (32),
        .DEPTH (BDO_DEPTH),
        .CW    (BDO_CW)
    ) u_bdo (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_clr   (w_fifo_clr),
        .i_push  (bdo_valid_i & ~w_bdo_full),
        .i_pop   (w_rd_bdo),
        .i_data  (bdo_data_i),
        .o_data  (w_bdo_head),
        .o_count (w_bdo_cnt),
        .o_full  (w_bdo_full),
        .o_empty (w_bdo_empty)
    );

    assign w_status = {8'h00, 8'(w_bdo_cnt), 8'(w_bdi_cnt), 1'b0, r_udf, r_ovf,
                       w_bdo_empty, w_bdi_full, r_busy, auth_i, r_done};

    always_comb begin
        w_rdata = c_BAD_READ;
        if (w_addr_ok) begin
            case (w_addr8)
                c_ADDR_CTRL:   w_rdata = {25'd0, 1'b0, r_irq_en, r_mode, 1'b0};
                c_ADDR_STATUS: w_rdata = w_status;
                c_ADDR_TYPE:   w_rdata = {28'd0, r_bdi_type};
                c_ADDR_BDO:    w_rdata = w_bdo_head;
                default:       w_rdata = c_BAD_READ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mode     <= '0;
            r_irq_en   <= 1'b0;
            r_start    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
            r_udf      <= 1'b0;
            r_irq      <= 1'b0;
            r_bdi_type <= '0;
            r_rdata    <= '0;
            r_rvalid   <= 1'b0;
            for (int i = 0; i < KEY_WORDS; i++) begin
                r_key[i] <= '0;
            end
            for (int i = 0; i < NONCE_WORDS; i++) begin
                r_nonce[i] <= '0;
            end
        end else begin
            r_start <= w_start_ok;
            if (w_start_ok) begin
                r_busy <= 1'b1;
            end else if (done_i) begin
                r_busy <= 1'b0;
            end
            if (w_wr_ctrl) begin
                r_mode   <= wdata_i[4:1];
                r_irq_en <= wdata_i[5];
            end
            if (w_wr_type) begin
                r_bdi_type <= wdata_i[3:0];
            end
            // Flag sources take priority over a same-cycle write-1-to-clear
            r_done <= done_i    | (r_done & ~(w_wr_status & wdata_i[0]));
            r_ovf  <= w_bdi_ovf | (r_ovf  & ~(w_wr_status & wdata_i[5]));
            r_udf  <= w_bdo_udf | (r_udf  & ~(w_wr_status & wdata_i[6]));
            r_irq  <= r_irq_en & (r_done | r_ovf | r_udf);
            for (int i = 0; i < KEY_WORDS; i++) begin
                if (w_wr && w_addr_ok && (w_addr8 == c_ADDR_KEY + 8'(4 * i))) begin
                    r_key[i] <= wdata_i;
                end
            end
            for (int i = 0; i < NONCE_WORDS; i++) begin
                if (w_wr && w_addr_ok && (w_addr8 == c_ADDR_NONCE + 8'(4 * i))) begin
                    r_nonce[i] <= wdata_i;
                end
            end
            r_rvalid <= w_rd;
            if (w_rd) begin
                r_rdata <= w_rdata;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < KEY_WORDS; gi++) begin : g_key
            assign key_o[32*gi +: 32] = r_key[gi];
        end
        for (genvar gi = 0; gi < NONCE_WORDS; gi++) begin : g_nonce
            assign nonce_o[32*gi +: 32] = r_nonce[gi];
        end
    endgenerate

    assign rdata_o     = r_rdata;
    assign rvalid_o    = r_rvalid;
    assign mode_o      = r_mode;
    assign start_o     = r_start;
    assign irq_o       = r_irq;
    assign bdi_data_o  = w_bdi_head[31:0];
    assign bdi_type_o  = w_bdi_head[35:32];
    assign bdi_valid_o = ~w_bdi_empty;
    assign bdo_ready_o = ~w_bdo_full;
endmodule

`default_nettype wire

// File: tb/tb_ascon_regs_fifo.sv
// ============================================================================
// Module      : tb_ascon_regs_fifo
// Description : Self-checking bench for ascon_regs_fifo against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ascon_regs_fifo;
    localparam int AW = 8;
    localparam int KW = 4;
    localparam int NW = 3;
    localparam int BD = 4;
    localparam int OD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          rvalid;
    logic [3:0]    mode;
    logic          start;
    logic          done;
    logic          auth;
    logic [32*KW-1:0] key;
    logic [32*NW-1:0] nonce;
    logic [31:0]   bdi_data;
    logic [3:0]    bdi_type;
    logic          bdi_valid;
    logic          bdi_ready;
    logic [31:0]   bdo_data;
    logic          bdo_valid;
    logic          bdo_ready;
    logic          irq;

    always #5 clk = ~clk;

    ascon_regs_fifo #(
        .ADDR_WIDTH (AW), .KEY_WORDS (KW), .NONCE_WORDS (NW),
        .BDI_DEPTH (BD), .BDO_DEPTH (OD)
    ) dut (
        .clk_i (clk), .rst_i (rst), .req_i (req), .we_i (we), .addr_i (addr),
        .wdata_i (wdata), .rdata_o (rdata), .rvalid_o (rvalid), .mode_o (mode),
        .start_o (start), .done_i (done), .auth_i (auth), .key_o (key),
        .nonce_o (nonce), .bdi_data_o (bdi_data), .bdi_type_o (bdi_type),
        .bdi_valid_o (bdi_valid), .bdi_ready_i (bdi_ready), .bdo_data_i (bdo_data),
        .bdo_valid_i (bdo_valid), .bdo_ready_o (bdo_ready), .irq_o (irq)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [35:0] q_bdi[$];
    logic [31:0] q_bdo[$];
    logic        m_done, m_ovf, m_udf, m_busy, m_irqen, m_start, m_irq, m_rvalid;
    logic [3:0]  m_mode, m_type;
    logic [31:0] m_rdata;
    logic [31:0] m_key   [KW];
    logic [31:0] m_nonce [NW];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [7:0] a);
        case (a)
            8'h00: return {26'd0, m_irqen, m_mode, 1'b0};
            8'h04: return {8'h00, 8'(q_bdo.size()), 8'(q_bdi.size()), 1'b0, m_udf, m_ovf,
                           q_bdo.size() == 0, q_bdi.size() == BD, m_busy, auth, m_done};
            8'h34: return {28'd0, m_type};
            8'h38: return (q_bdo.size() > 0) ? q_bdo[0] : 32'd0;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Advance the model by one clock using the inputs currently applied
    task automatic model_step();
        logic        rd, wr, bdi_pop, start_n, ovf_set, udf_set, bdo_was_full, irq_n;
        logic [31:0] w1c;
        if (rst) begin
            q_bdi.delete(); q_bdo.delete();
            m_done = 0; m_ovf = 0; m_udf = 0; m_busy = 0; m_irqen = 0; m_start = 0;
            m_irq = 0; m_rvalid = 0; m_mode = 0; m_type = 0; m_rdata = 0;
            for (int i = 0; i < KW; i++) m_key[i] = 0;
            for (int i = 0; i < NW; i++) m_nonce[i] = 0;
            return;
        end
        rd = req & ~we;
        wr = req & we;
        irq_n = m_irqen & (m_done | m_ovf | m_udf);
        if (rd) begin
            m_rdata  = model_read(addr);
            m_rvalid = 1;
        end else begin
            m_rvalid = 0;
        end
        start_n = wr && addr == 8'h00 && wdata[0] && !m_busy;
        bdi_pop = bdi_ready && q_bdi.size() > 0;
        ovf_set = wr && addr == 8'h30 && q_bdi.size() == BD && !bdi_pop;
        if (bdi_pop) void'(q_bdi.pop_front());
        if (wr && addr == 8'h30 && !ovf_set) q_bdi.push_back({m_type, wdata});
        udf_set = rd && addr == 8'h38 && q_bdo.size() == 0;
        bdo_was_full = (q_bdo.size() == OD);
        if (rd && addr == 8'h38 && q_bdo.size() > 0) void'(q_bdo.pop_front());
        if (bdo_valid && !bdo_was_full) q_bdo.push_back(bdo_data);
        w1c = (wr && addr == 8'h04) ? wdata : 32'd0;
        m_done = done    | (m_done & ~w1c[0]);
        m_ovf  = ovf_set | (m_ovf  & ~w1c[5]);
        m_udf  = udf_set | (m_udf  & ~w1c[6]);
        if (start_n) m_busy = 1;
        else if (done) m_busy = 0;
        if (wr && addr == 8'h00) begin
            m_mode  = wdata[4:1];
            m_irqen = wdata[5];
            if (wdata[6]) begin
                q_bdi.delete();
                q_bdo.delete();
            end
        end
        if (wr && addr == 8'h34) m_type = wdata[3:0];
        for (int i = 0; i < KW; i++) if (wr && addr == 8'(8'h08 + 4 * i)) m_key[i] = wdata;
        for (int i = 0; i < NW; i++) if (wr && addr == 8'(8'h20 + 4 * i)) m_nonce[i] = wdata;
        m_start = start_n;
        m_irq   = irq_n;
    endtask

    // One clock: update model, let the DUT see the edge, compare at the negedge
    task automatic cyc();
        logic [32*KW-1:0] ek;
        logic [32*NW-1:0] en;
        model_step();
        @(negedge clk);
        for (int i = 0; i < KW; i++) ek[32*i +: 32] = m_key[i];
        for (int i = 0; i < NW; i++) en[32*i +: 32] = m_nonce[i];
        chk("start_o", start, m_start);
        chk("mode_o", mode, m_mode);
        chk("irq_o", irq, m_irq);
        chk("rvalid_o", rvalid, m_rvalid);
        if (m_rvalid) chk("rdata_o", rdata, m_rdata);
        chk("bdi_valid_o", bdi_valid, q_bdi.size() > 0);
        if (q_bdi.size() > 0) chk("bdi_head", {bdi_type, bdi_data}, q_bdi[0]);
        chk("bdo_ready_o", bdo_ready, q_bdo.size() < OD);
        chk("key_o", key, ek);
        chk("nonce_o", nonce, en);
    endtask

    task automatic bus(input logic w, input logic [7:0] a, input logic [31:0] d);
        req = 1; we = w; addr = a; wdata = d;
        cyc();
        req = 0; we = 0;
    endtask

    logic [7:0] tbl [12];

    initial begin
        rst = 1; req = 0; we = 0; addr = 0; wdata = 0; done = 0; auth = 0;
        bdi_ready = 0; bdo_data = 0; bdo_valid = 0;
        tbl = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h14, 8'h20, 8'h28, 8'h30,
                8'h34, 8'h38, 8'h3C, 8'hFC};
        @(negedge clk);
        cyc();
        rst = 0;

        // 1: reset after registers were written
        bus(1, 8'h08, 32'hCAFE_0001);
        bus(1, 8'h24, 32'hCAFE_0002);
        bus(1, 8'h00, 32'h0000_0034);
        bus(1, 8'h34, 32'h7);
        bus(1, 8'h30, 32'h1234_5678);
        rst = 1; cyc(); rst = 0;
        chk("rst_key", key, 0);
        chk("rst_nonce", nonce, 0);
        chk("rst_mode", mode, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_bdi_valid", bdi_valid, 0);
        chk("rst_bdo_ready", bdo_ready, 1);
        bus(0, 8'h04, 0);
        chk("rst_status", rdata, 32'h0000_0010);

        // 2: start pulse, busy, done, irq
        bus(1, 8'h00, 32'h0000_0023);
        chk("start_hi", start, 1);
        chk("mode_1", mode, 4'h1);
        cyc();
        chk("start_lo", start, 0);
        bus(0, 8'h04, 0);
        chk("busy_set", rdata[2], 1);
        bus(1, 8'h00, 32'h0000_0023);
        chk("start_ignored", start, 0);
        done = 1; cyc(); done = 0;
        cyc();
        chk("irq_set", irq, 1);
        bus(0, 8'h04, 0);
        chk("done_busy", rdata[2:0], 3'b001);
        bus(1, 8'h04, 32'h1);
        cyc();
        chk("irq_clr", irq, 0);

        // 3: BDI fill with overflow, then drain
        bus(1, 8'h34, 32'h5);
        for (int k = 0; k < 5; k++) bus(1, 8'h30, 32'h1111_1111 * (k + 1));
        bus(0, 8'h04, 0);
        chk("bdi_cnt4", rdata[15:8], 8'd4);
        chk("bdi_ovf", rdata[5], 1);
        bdi_ready = 1;
        for (int k = 0; k < 4; k++) begin
            chk("bdi_pop_data", bdi_data, 32'h1111_1111 * (k + 1));
            chk("bdi_pop_type", bdi_type, 4'h5);
            cyc();
        end
        bdi_ready = 0;
        chk("bdi_drained", bdi_valid, 0);

        // 4: BDO fill and bus pops, then underflow
        bdo_valid = 1;
        for (int k = 0; k < 4; k++) begin
            bdo_data = 32'hA0 + k;
            cyc();
        end
        bdo_valid = 0;
        chk("bdo_full", bdo_ready, 0);
        for (int k = 0; k < 4; k++) begin
            bus(0, 8'h38, 0);
            chk("bdo_pop_data", rdata, 32'hA0 + k);
        end
        bus(0, 8'h38, 0);
        chk("bdo_udf_data", rdata, 0);
        bus(0, 8'h04, 0);
        chk("bdo_udf_flag", rdata[6], 1);

        // 5: full BDI push with simultaneous pop, then FIFO_CLR
        bus(1, 8'h04, 32'h20);
        for (int k = 0; k < 4; k++) bus(1, 8'h30, 32'hB0 + k);
        bdi_ready = 1;
        bus(1, 8'h30, 32'hB4);
        bdi_ready = 0;
        bus(0, 8'h04, 0);
        chk("pushpop_cnt", rdata[15:8], 8'd4);
        chk("pushpop_no_ovf", rdata[5], 0);
        bdo_valid = 1; bdo_data = 32'h5555; cyc(); cyc(); bdo_valid = 0;
        bus(1, 8'h00, 32'h62);
        bus(0, 8'h04, 0);
        chk("clr_counts", rdata[23:8], 16'h0);
        chk("clr_keeps_udf", rdata[6], 1);

        // 6: unmapped / write-only reads, reset mid-burst
        bus(0, 8'h08, 0);
        chk("rd_key", rdata, 32'hDEAD_BEEF);
        bus(0, 8'h3C, 0);
        chk("rd_3c", rdata, 32'hDEAD_BEEF);
        bus(0, 8'hFC, 0);
        chk("rd_fc", rdata, 32'hDEAD_BEEF);
        bus(1, 8'h30, 32'h77);
        bdo_valid = 1; bdo_data = 32'h88; cyc(); bdo_valid = 0;
        req = 1; we = 0; addr = 8'h04; rst = 1;
        cyc();
        rst = 0; req = 0;
        chk("rst_mid_rvalid", rvalid, 0);
        chk("rst_mid_bdi", bdi_valid, 0);
        chk("rst_mid_bdo", bdo_ready, 1);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rst   = ($urandom_range(0, 299) == 0);
            req   = 1'($urandom_range(0, 1));
            we    = 1'($urandom_range(0, 1));
            addr  = tbl[$urandom_range(0, 11)];
            wdata = $urandom;
            if (addr == 8'h00 && $urandom_range(0, 3) != 0) wdata[6] = 1'b0;
            done      = ($urandom_range(0, 15) == 0);
            auth      = 1'($urandom_range(0, 1));
            bdi_ready = ($urandom_range(0, 2) == 0);
            bdo_valid = 1'($urandom_range(0, 1));
            bdo_data  = $urandom;
            cyc();
        end
        rst = 0; req = 0; done = 0; bdo_valid = 0; bdi_ready = 0;
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
